// File: rtl/riscv_icache_refill_ctrl_if.sv
// riscv_icache_refill_ctrl_if: fetch, instruction-RAM and data-array signals of the I-cache refill controller
//   master (controller) inputs : fetch_req, fetch_addr, flush, mem_data
//   master (controller) outputs: hit, stall, mem_rden, mem_addr, line_we, line_index, line_data
//   slave is the mirror image, used by whatever drives the fetch side and models the RAM
//   ICACHE_PERF_CNT_EN adds the hit_count/miss_count outputs
interface riscv_icache_refill_ctrl_if #(
   parameter int ADDR       = 14,
   parameter int S_ADDR     = 10,
   parameter int INDEX      = 8,
   parameter int DATA_WIDTH = 128
);
   logic                  fetch_req;
   logic [ADDR-1:0]       fetch_addr;
   logic                  flush;
   logic                  hit;
   logic                  stall;
   logic                  mem_rden;
   logic [S_ADDR-1:0]     mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  line_we;
   logic [INDEX-1:0]      line_index;
   logic [DATA_WIDTH-1:0] line_data;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0]           hit_count;
   logic [31:0]           miss_count;
`endif
   modport master (
      input  fetch_req, fetch_addr, flush, mem_data,
      output hit, stall, mem_rden, mem_addr, line_we, line_index, line_data
`ifdef ICACHE_PERF_CNT_EN
      , output hit_count, miss_count
`endif
   );
   modport slave (
      output fetch_req, fetch_addr, flush, mem_data,
      input  hit, stall, mem_rden, mem_addr, line_we, line_index, line_data
`ifdef ICACHE_PERF_CNT_EN
      , input hit_count, miss_count
`endif
   );
endinterface

// File: rtl/riscv_icache_refill_ctrl.sv
// riscv_icache_refill_ctrl: direct-mapped I-cache tag/valid owner and single-outstanding line refill FSM
//   clk, rst_n : clock (rising edge) and synchronous active-low reset
//   bus.master : fetch_req/fetch_addr/flush in, hit/stall out; mem_rden/mem_addr out, mem_data in;
//                line_we/line_index/line_data out to the data array
//   ICACHE_PERF_CNT_EN : when defined, adds hit_count and miss_count
module riscv_icache_refill_ctrl #(
   parameter int DATA_WIDTH  = 128,
   parameter int CACHE_SIZE  = 4096,
   parameter int MEM_SIZE    = 16384,
   parameter int DATAPBLOCK  = 16,
   parameter int CACHE_DEPTH = CACHE_SIZE / DATAPBLOCK,
   parameter int ADDR        = $clog2(MEM_SIZE),
   parameter int BYTE_OFF    = $clog2(DATAPBLOCK),
   parameter int INDEX       = $clog2(CACHE_DEPTH),
   parameter int TAG         = ADDR - BYTE_OFF - INDEX,
   parameter int S_ADDR      = ADDR - BYTE_OFF,
   parameter int MEM_LAT     = 1
) (
   input logic                       clk,
   input logic                       rst_n,
   riscv_icache_refill_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
   state_t                state;
   logic [CACHE_DEPTH-1:0] valid;
   logic [TAG-1:0]        tag_arr [CACHE_DEPTH];
   logic [S_ADDR-1:0]     miss_addr;
   logic [3:0]            cnt;
   logic                  flush_pend;
   logic                  rden;
   logic                  we;
   logic [INDEX-1:0]      lidx;
   logic [INDEX-1:0]      idx;
   logic [INDEX-1:0]      miss_idx;
   logic                  hit;
   logic                  take_miss;
   logic [DATA_WIDTH-1:0] fill_data;
   assign idx      = bus.fetch_addr[BYTE_OFF+INDEX-1:BYTE_OFF];
   assign miss_idx = miss_addr[INDEX-1:0];
   // a flush arriving this cycle also suppresses the hit: the line is about to be invalidated
   assign hit = state == IDLE && bus.fetch_req && valid[idx] &&
                tag_arr[idx] == bus.fetch_addr[ADDR-1:ADDR-TAG] && !flush_pend && !bus.flush;
   assign take_miss = state == IDLE && !flush_pend && !bus.flush && bus.fetch_req && !hit;
   assign fill_data      = bus.mem_data;
   assign bus.hit        = hit;
   assign bus.stall      = (bus.fetch_req && !hit) || state != IDLE;
   assign bus.mem_rden   = rden;
   assign bus.mem_addr   = miss_addr;
   assign bus.line_we    = we;
   assign bus.line_index = lidx;
   assign bus.line_data  = fill_data;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         valid      <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         miss_addr  <= '0;
         rden       <= 1'b0;
         we         <= 1'b0;
         lidx       <= '0;
      end else begin
         rden <= 1'b0;
         we   <= 1'b0;
         case (state)
            IDLE: begin
               if (flush_pend || bus.flush) begin
                  valid      <= '0;
                  flush_pend <= 1'b0;
               end else if (take_miss) begin
                  miss_addr <= bus.fetch_addr[ADDR-1:BYTE_OFF];
                  rden      <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               cnt <= 4'(MEM_LAT - 1);
               if (MEM_LAT == 1) begin
                  state <= FILL;
                  we    <= 1'b1;
                  lidx  <= miss_idx;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= FILL;
                  we    <= 1'b1;
                  lidx  <= miss_idx;
               end
            end
            FILL: begin
               valid[miss_idx] <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // a flush seen mid-refill is deferred so the fill still lands, then gets wiped in IDLE
         if (state != IDLE && bus.flush) flush_pend <= 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (rst_n && state == FILL) tag_arr[miss_idx] <= miss_addr[S_ADDR-1:INDEX];
`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.hit_count  <= '0;
         bus.miss_count <= '0;
      end else begin
         if (hit) bus.hit_count <= bus.hit_count + 32'd1;
         if (take_miss) bus.miss_count <= bus.miss_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_riscv_icache_refill_ctrl.sv
// tb_riscv_icache_refill_ctrl: checks MEM_LAT=1 and MEM_LAT=4 controllers side by side against a line-level cache model
module tb_riscv_icache_refill_ctrl;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req = 1'b0;
   logic         fl = 1'b0;
   logic [13:0]  addr = '0;
   logic [127:0] mdata = '0;
   always #5 clk = ~clk;
   riscv_icache_refill_ctrl_if b1();
   riscv_icache_refill_ctrl_if b4();
   assign b1.fetch_req  = req;
   assign b1.fetch_addr = addr;
   assign b1.flush      = fl;
   assign b1.mem_data   = mdata;
   assign b4.fetch_req  = req;
   assign b4.fetch_addr = addr;
   assign b4.flush      = fl;
   assign b4.mem_data   = mdata;
   riscv_icache_refill_ctrl #(.MEM_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   riscv_icache_refill_ctrl #(.MEM_LAT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   logic         o_hit [2];
   logic         o_stall [2];
   logic         o_rden [2];
   logic         o_we [2];
   logic [9:0]   o_ma [2];
   logic [7:0]   o_li [2];
   logic [127:0] o_ld [2];
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0]  o_hc [2];
   logic [31:0]  o_mc [2];
`endif
   // model: per-line valid/tag, plus the number of cycles a refill still keeps the controller busy
   int lat [2] = '{1, 4};
   bit mv [2][256];
   int mt [2][256];
   int busy [2];
   int mblk [2];
   int lidx [2];
   bit pend [2];
   int hc [2];
   int mc [2];
   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;
   typedef struct {
      bit          req;
      logic [13:0] addr;
      bit          fl;
      bit          hit;
      bit          stall;
      bit          rden;
      bit          we;
   } vec_t;
   vec_t tbl [$];
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic check(string nm, int k, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s (MEM_LAT=%0d): got %0h want %0h", nm, lat[k], got, exp);
      end
   endtask
   task automatic step();
      bit eh, es, er, ew;
      int ix, tg, li;
      @(negedge clk);
      o_hit   = '{b1.hit, b4.hit};
      o_stall = '{b1.stall, b4.stall};
      o_rden  = '{b1.mem_rden, b4.mem_rden};
      o_we    = '{b1.line_we, b4.line_we};
      o_ma    = '{b1.mem_addr, b4.mem_addr};
      o_li    = '{b1.line_index, b4.line_index};
      o_ld    = '{b1.line_data, b4.line_data};
`ifdef ICACHE_PERF_CNT_EN
      o_hc    = '{b1.hit_count, b4.hit_count};
      o_mc    = '{b1.miss_count, b4.miss_count};
`endif
      ix = int'(addr[11:4]);
      tg = int'(addr[13:12]);
      for (int k = 0; k < 2; k++) begin
         eh = busy[k] == 0 && req && mv[k][ix] && mt[k][ix] == tg && !pend[k] && !fl;
         es = busy[k] != 0 || (req && !eh);
         er = busy[k] == lat[k] + 1;
         ew = busy[k] == 1;
         if (chk_en) begin
            check("hit", k, int'(o_hit[k]), int'(eh));
            check("stall", k, int'(o_stall[k]), int'(es));
            check("mem_rden", k, int'(o_rden[k]), int'(er));
            check("line_we", k, int'(o_we[k]), int'(ew));
            check("mem_addr", k, int'(o_ma[k]), mblk[k]);
            check("line_index", k, int'(o_li[k]), lidx[k]);
            if (ew) begin
               n_cmp++;
               if (o_ld[k] !== mdata) begin
                  n_bad++;
                  $display("FAIL line_data (MEM_LAT=%0d): got %h want %h", lat[k], o_ld[k], mdata);
               end
            end
`ifdef ICACHE_PERF_CNT_EN
            check("hit_count", k, int'(o_hc[k]), hc[k]);
            check("miss_count", k, int'(o_mc[k]), mc[k]);
`endif
         end
         if (!rst_n) begin
            busy[k] = 0; pend[k] = 0; mblk[k] = 0; lidx[k] = 0; hc[k] = 0; mc[k] = 0;
            for (int i = 0; i < 256; i++) mv[k][i] = 0;
         end else begin
            if (eh) hc[k]++;
            if (busy[k] == 0) begin
               if (pend[k] || fl) begin
                  for (int i = 0; i < 256; i++) mv[k][i] = 0;
                  pend[k] = 0;
               end else if (req && !eh) begin
                  busy[k] = lat[k] + 1;
                  mblk[k] = int'(addr[13:4]);
                  mc[k]++;
               end
            end else begin
               li = mblk[k] % 256;
               if (fl) pend[k] = 1;
               if (busy[k] == 2) lidx[k] = li;
               if (busy[k] == 1) begin
                  mv[k][li] = 1;
                  mt[k][li] = mblk[k] / 256;
               end
               busy[k]--;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle(int n);
      req = 0; fl = 0; rst_n = 1;
      repeat (n) step();
   endtask
   task automatic add(bit r, logic [13:0] a, bit f, bit h, bit s, bit d, bit w);
      vec_t e;
      e.req = r; e.addr = a; e.fl = f; e.hit = h; e.stall = s; e.rden = d; e.we = w;
      tbl.push_back(e);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end
   initial begin
      int nst, c_r, c_w, c_h, nwe;
      logic [7:0] ipool [4];
      ipool = '{8'h00, 8'h04, 8'hFF, 8'h7F};
      // expectations for the MEM_LAT=1 instance
      add(1, 14'h0040, 0, 0, 1, 0, 0); add(1, 14'h0040, 0, 0, 1, 1, 0);
      add(1, 14'h0040, 0, 0, 1, 0, 1); add(1, 14'h0040, 0, 1, 0, 0, 0);
      add(1, 14'h004C, 0, 1, 0, 0, 0);
      add(1, 14'h1040, 0, 0, 1, 0, 0); add(1, 14'h1040, 0, 0, 1, 1, 0);
      add(1, 14'h1040, 0, 0, 1, 0, 1); add(1, 14'h1040, 0, 1, 0, 0, 0);
      add(1, 14'h0040, 0, 0, 1, 0, 0); add(1, 14'h0040, 0, 0, 1, 1, 0);
      add(1, 14'h0040, 0, 0, 1, 0, 1); add(1, 14'h0040, 0, 1, 0, 0, 0);
      add(0, 14'h0040, 1, 0, 0, 0, 0);
      add(1, 14'h0040, 0, 0, 1, 0, 0); add(1, 14'h0040, 1, 0, 1, 1, 0);
      add(1, 14'h0040, 0, 0, 1, 0, 1); add(1, 14'h0040, 0, 0, 1, 0, 0);
      add(1, 14'h0040, 0, 0, 1, 0, 0); add(1, 14'h0040, 0, 0, 1, 1, 0);
      add(1, 14'h0040, 0, 0, 1, 0, 1); add(1, 14'h0040, 0, 1, 0, 0, 0);
      add(1, 14'h3FF0, 1, 0, 1, 0, 0); add(1, 14'h3FF0, 0, 0, 1, 0, 0);
      add(1, 14'h3FF0, 0, 0, 1, 1, 0); add(1, 14'h3FF0, 0, 0, 1, 0, 1);
      add(1, 14'h3FF0, 0, 1, 0, 0, 0); add(0, 14'h3FF0, 0, 0, 0, 0, 0);
      add(1, 14'h0200, 0, 0, 1, 0, 0); add(0, 14'h1234, 0, 0, 1, 1, 0);
      add(0, 14'h1234, 0, 0, 1, 0, 1); add(1, 14'h0200, 0, 1, 0, 0, 0);
      rst_n = 0;
      step();
      chk_en = 1;
      req = 1;
      step();
      idle(1);
      foreach (tbl[i]) begin
         req = tbl[i].req; addr = tbl[i].addr; fl = tbl[i].fl; mdata = rnd128();
         step();
         check($sformatf("vec%0d.hit", i), 0, int'(o_hit[0]), int'(tbl[i].hit));
         check($sformatf("vec%0d.stall", i), 0, int'(o_stall[0]), int'(tbl[i].stall));
         check($sformatf("vec%0d.rden", i), 0, int'(o_rden[0]), int'(tbl[i].rden));
         check($sformatf("vec%0d.we", i), 0, int'(o_we[0]), int'(tbl[i].we));
      end
      // MEM_LAT=4 cold miss timing
      idle(6);
      req = 1; addr = 14'h0100; nst = 0; c_r = -1; c_w = -1; c_h = -1;
      for (int c = 0; c < 12 && c_h < 0; c++) begin
         mdata = rnd128();
         step();
         if (o_stall[1]) nst++;
         if (o_rden[1]) c_r = c;
         if (o_we[1]) c_w = c;
         if (o_hit[1]) c_h = c;
      end
      check("lat4.stall_cycles", 1, nst, 6);
      check("lat4.rden_cycle", 1, c_r, 1);
      check("lat4.we_cycle", 1, c_w, 5);
      check("lat4.hit_cycle", 1, c_h, 6);
      // flush while the MEM_LAT=4 refill waits
      idle(6);
      req = 1; addr = 14'h0180;
      for (int c = 0; c < 9; c++) begin
         fl = c == 2;
         mdata = rnd128();
         step();
         if (c == 5) check("flush.fill_we", 1, int'(o_we[1]), 1);
         if (c == 6) check("flush.clear_hit", 1, int'(o_hit[1]), 0);
         if (c == 6) check("flush.clear_stall", 1, int'(o_stall[1]), 1);
         if (c == 8) check("flush.refetch_rden", 1, int'(o_rden[1]), 1);
      end
      // reset while the MEM_LAT=4 refill waits
      idle(6);
      addr = 14'h0280; nwe = 0;
      for (int c = 0; c < 10; c++) begin
         rst_n = c != 2;
         req = c < 2 || c >= 8;
         mdata = rnd128();
         step();
         if (c >= 2 && o_we[1]) nwe++;
         if (c == 3) check("rst.stall", 1, int'(o_stall[1]), 0);
         if (c == 3) check("rst.rden", 1, int'(o_rden[1]), 0);
`ifdef ICACHE_PERF_CNT_EN
         if (c == 3) check("rst.hit_count", 1, int'(o_hc[1]), 0);
         if (c == 3) check("rst.miss_count", 1, int'(o_mc[1]), 0);
`endif
         if (c == 8) check("rst.refetch_hit", 1, int'(o_hit[1]), 0);
         if (c == 9) check("rst.refetch_rden", 1, int'(o_rden[1]), 1);
      end
      check("rst.no_line_we", 1, nwe, 0);
      // random traffic over a few conflicting lines
      idle(6);
      for (int i = 0; i < 800; i++) begin
         rst_n = $urandom_range(99) >= 2;
         req = $urandom_range(3) != 0;
         fl = $urandom_range(24) == 0;
         if ($urandom_range(1) == 0)
            addr = {2'($urandom_range(3)), ipool[$urandom_range(3)], 4'($urandom_range(15))};
         mdata = rnd128();
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
